// File: rtl/answer_capture_if.sv
// Player-input bus of the LED memory game answer stage.
// The master side is the surrounding game (display stage, switches, button and
// compare stage). The slave side is answer_capture.
interface answer_capture_if #(
    parameter int N_SW    = 10,
    parameter int TIMER_W = 16
);
    logic                start;
    logic [N_SW-1:0]     switch;
    logic                submit;
    logic [N_SW-1:0]     my_sol;
    logic                done;
    logic                time_out;
    logic                busy;
    logic [TIMER_W-1:0]  remaining;

    modport master (
        output start, switch, submit,
        input  my_sol, done, time_out, busy, remaining
    );

    modport slave (
        input  start, switch, submit,
        output my_sol, done, time_out, busy, remaining
    );
endinterface

// File: rtl/answer_capture.sv
// Answer capture stage.
// The stage opens an answer window when the display stage signals that the
// pattern has been shown. It synchronizes and debounces the slide switches.
// It latches the debounced answer on a fresh submit press or on window timeout.
// It then hands my_sol to the compare stage together with a one-cycle done pulse.
// Every output is driven straight from a flop.
module answer_capture #(
    parameter int N_SW            = 10,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter int TIMER_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    answer_capture_if.slave   bus
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Input synchronizers.
    // sw_prev_q holds the synchronized switch vector from the previous cycle.
    logic [N_SW-1:0] sw_s1_q, sw_s1_d;
    logic [N_SW-1:0] sw_s2_q, sw_s2_d;
    logic [N_SW-1:0] sw_prev_q, sw_prev_d;
    logic            sub_s1_q, sub_s1_d;
    logic            sub_s2_q, sub_s2_d;
    logic            sub_s3_q, sub_s3_d;
    logic            sub_edge_s;

    // Debouncer
    logic [CNT_W-1:0] dbc_cnt_q, dbc_cnt_d;
    logic [N_SW-1:0]  sw_stable_q, sw_stable_d;

    // Window FSM and its registered outputs
    state_t           state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [N_SW-1:0]  my_sol_q, my_sol_d;
    logic             done_q, done_d;
    logic             time_out_q, time_out_d;
    logic             busy_q, busy_d;

    // Next value of each stage in the synchronizer chains.
    always_comb begin
        sw_s1_d   = bus.switch;
        sw_s2_d   = sw_s1_q;
        sw_prev_d = sw_s2_q;
        sub_s1_d  = bus.submit;
        sub_s2_d  = sub_s1_q;
        sub_s3_d  = sub_s2_q;
    end

    // A submit press counts only on the 0->1 transition of the synchronized button.
    // A button held down across windows therefore never re-triggers.
    assign sub_edge_s = sub_s2_q & ~sub_s3_q;

    // Debounce counter.
    // Any change of the synchronized vector restarts the count.
    // sw_stable takes the new value only after the vector has held still long enough.
    always_comb begin
        dbc_cnt_d   = dbc_cnt_q;
        sw_stable_d = sw_stable_q;
        if (sw_s2_q != sw_prev_q) begin
            dbc_cnt_d = {CNT_W{1'b0}};
        end else begin
            if (dbc_cnt_q == CNT_MAX) begin
                sw_stable_d = sw_s2_q;
            end else begin
                dbc_cnt_d = dbc_cnt_q + CNT_W'(1);
            end
        end
    end

    // Window FSM next state and next output values.
    // The timer doubles as the remaining count and is held at zero outside WAIT.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        my_sol_d   = my_sol_q;
        done_d     = 1'b0;
        time_out_d = time_out_q;
        busy_d     = busy_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = WAIT;
                    timer_d    = TIMER_LOAD;
                    time_out_d = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    timer_d = {TIMER_W{1'b0}};
                    busy_d  = 1'b0;
                end
            end
            WAIT: begin
                // Submit takes priority over the timer expiring in the same cycle.
                if (sub_edge_s) begin
                    state_d    = DONE;
                    my_sol_d   = sw_stable_q;
                    time_out_d = 1'b0;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    timer_d    = {TIMER_W{1'b0}};
                end else if (timer_q == {TIMER_W{1'b0}}) begin
                    state_d    = DONE;
                    my_sol_d   = sw_stable_q;
                    time_out_d = 1'b1;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                    busy_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                timer_d = {TIMER_W{1'b0}};
            end
            default: begin
                state_d    = IDLE;
                timer_d    = {TIMER_W{1'b0}};
                busy_d     = 1'b0;
                time_out_d = 1'b0;
            end
        endcase
    end

    // Synchronizer and debouncer state, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_s1_q     <= {N_SW{1'b0}};
            sw_s2_q     <= {N_SW{1'b0}};
            sw_prev_q   <= {N_SW{1'b0}};
            sub_s1_q    <= 1'b0;
            sub_s2_q    <= 1'b0;
            sub_s3_q    <= 1'b0;
            dbc_cnt_q   <= {CNT_W{1'b0}};
            sw_stable_q <= {N_SW{1'b0}};
        end else begin
            sw_s1_q     <= sw_s1_d;
            sw_s2_q     <= sw_s2_d;
            sw_prev_q   <= sw_prev_d;
            sub_s1_q    <= sub_s1_d;
            sub_s2_q    <= sub_s2_d;
            sub_s3_q    <= sub_s3_d;
            dbc_cnt_q   <= dbc_cnt_d;
            sw_stable_q <= sw_stable_d;
        end
    end

    // FSM state and registered outputs.
    // An asynchronous reset aborts any open window without producing a done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            timer_q    <= {TIMER_W{1'b0}};
            my_sol_q   <= {N_SW{1'b0}};
            done_q     <= 1'b0;
            time_out_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            my_sol_q   <= my_sol_d;
            done_q     <= done_d;
            time_out_q <= time_out_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.my_sol    = my_sol_q;
    assign bus.done      = done_q;
    assign bus.time_out  = time_out_q;
    assign bus.busy      = busy_q;
    assign bus.remaining = timer_q;

endmodule

// File: doc/answer_capture.md
Name: answer_capture

Overview:
- Player-input stage of the LED memory game. Sits between the LED-pattern display stage and the compare stage.
- Opens an answer window when the display stage finishes.
- Synchronizes and debounces the 10 slide switches, then latches the player's answer on a submit press or on timeout.
- Hands the latched answer (my_sol) and a one-cycle done pulse to the compare stage.

Parameters:
- N_SW, 10, number of switches and width of the answer.
- DEBOUNCE_CYCLES, 4, consecutive identical synchronized samples needed before the debounced switch vector updates (≥1).
- TIMEOUT_CYCLES, 64, answer-window length in clocks (≥2).
- TIMER_W, 16, width of the window timer. Must satisfy TIMEOUT_CYCLES ≤ 2^TIMER_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse from the display stage ("pattern shown").
- switch  in  N_SW  raw asynchronous slide-switch inputs.
- submit  in  1  raw asynchronous push-button, active-high.
- my_sol  out  N_SW  latched answer, held stable until the next capture.
- done  out  1  one-cycle pulse: my_sol is valid.
- time_out  out  1  last capture was caused by timeout.
- busy  out  1  answer window open.
- remaining  out  TIMER_W  clocks left in the window; 0 when not busy.

Behaviour:
- Reset: the clock and reset are a single clock with an asynchronous, active-low reset, as decided. While reset=0, all of the following are 0: state=IDLE, my_sol, done, time_out, busy, remaining, synchronizers, debounce counter, debounced vector sw_stable. Reset asserted mid-window aborts the window; no done pulse is produced.
- Synchronization: switch and submit each pass through 2 flip-flops (s1, s2). A third flop s3 on submit gives the rising-edge detect sub_edge = s2 & ~s3.
- Debounce: the counter resets to 0 whenever the synchronized switch vector differs from its previous-cycle value. Otherwise it increments, saturating. When it reaches DEBOUNCE_CYCLES-1, sw_stable ← synchronized vector. The debouncer runs in all states.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - busy=0, remaining=0.
  - start=1 → WAIT; timer ← TIMEOUT_CYCLES-1; time_out ← 0.
  - sub_edge is ignored.
- WAIT:
  - busy=1, remaining=timer. The timer decrements by 1 each cycle.
  - sub_edge=1 → my_sol ← sw_stable, time_out ← 0, → DONE.
  - Else if timer==0 → my_sol ← sw_stable, time_out ← 1, → DONE.
  - sub_edge and timer==0 in the same cycle: submit wins, time_out=0.
  - start while in WAIT is ignored; the timer is not reloaded.
- DONE:
  - done=1 for exactly this one cycle, busy=0, remaining=0.
  - Unconditional transition → IDLE. A start in DONE is ignored.
- Latency:
  - Let k be the first clk edge that samples submit=1 while in WAIT, with submit previously low.
  - my_sol updates at edge k+2.
  - done is high between edges k+2 and k+3.
- Timeout window: exactly TIMEOUT_CYCLES clocks in WAIT, then one cycle in DONE.
- Held outputs: my_sol and time_out hold until the next capture (time_out also clears on the next start). Switch changes outside WAIT never alter my_sol.
- Submit held across windows: a submit held high from before start produces no edge. The player must release and press again.
- Switch bounce: bounce shorter than DEBOUNCE_CYCLES leaves sw_stable unchanged. The latched answer is always sw_stable, never the raw or synchronized value.

Test Plan:
1. Hold reset=0 with switch=10'h3FF and submit=1, then release → all outputs 0, state IDLE, and no done pulse for 100 cycles.
2. Set switch=10'h2A5 and let it settle 10 cycles. Pulse start, wait 5 cycles, raise submit → done pulses once exactly 2 edges after submit is sampled; my_sol=10'h2A5, time_out=0; busy falls in the done cycle.
3. Pulse start with no submit → busy=1 for 64 cycles, remaining counts 63→0, then done=1 with time_out=1 and my_sol=current sw_stable; back in IDLE afterwards.
4. Set switch=10'h001 and settle, then toggle bit 9 for 2 cycles only (< DEBOUNCE_CYCLES). Submit → my_sol=10'h001. Repeat with the toggle held 6 cycles → my_sol=10'h201.
5. Time submit so sub_edge coincides with timer==0 → done=1, time_out=0. Also pulse start mid-WAIT → remaining keeps decrementing with no reload.
6. Assert reset=0 in WAIT with remaining=30 → immediate clear, no done. After release, a new start opens a full 64-cycle window.
